// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the memory-access stage: FSM encoding and alignment mask.
package mem_access_unit_pkg;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;
  localparam logic [1:0] ALIGN_MASK = 2'b11;
endpackage

// File: rtl/mem_access_unit_if.sv
// Data-bus req/ack channel between the memory stage (master) and the memory system (slave).
interface mem_access_unit_if;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic        dbus_err;
  logic [31:0] dbus_rdata;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_wdata,
    input  dbus_ack, dbus_err, dbus_rdata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_wdata,
    output dbus_ack, dbus_err, dbus_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory stage: issues load/store on the data bus, stalls earlier stages until completion,
// and registers the MEM/WB result; aligned accesses stay 3+ cycles, everything else 1.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [4:0]               mrn,
  input  logic [31:0]              mb,
  input  logic [31:0]              malu,
  input  logic                     mwmem,
  input  logic                     mm2reg,
  input  logic                     mwreg,
  mem_access_unit_if.master        dbus,
  output logic                     mem_stall,
  output logic                     mem_fault,
  output logic [4:0]               wrn,
  output logic [31:0]              wdata,
  output logic                     wwreg
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      rdata_q;
  logic             fault_q;

  logic access;
  logic is_load;
  logic misaligned;
  logic timeout;

  // A simultaneous store+load request is treated as a store.
  assign access     = mwmem | mm2reg;
  assign is_load    = mm2reg & ~mwmem;
  assign misaligned = (malu[1:0] & ALIGN_MASK) != 2'b00;
  assign timeout    = (cnt == CNT_W'(TIMEOUT_CYCLES));

  assign mem_stall = (state == ST_WAIT) ||
                     ((state == ST_IDLE) && access && !misaligned);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      rdata_q         <= '0;
      fault_q         <= 1'b0;
      dbus.dbus_req   <= 1'b0;
      dbus.dbus_we    <= 1'b0;
      dbus.dbus_addr  <= '0;
      dbus.dbus_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (access && !misaligned) begin
            dbus.dbus_req   <= 1'b1;
            dbus.dbus_we    <= mwmem;
            dbus.dbus_addr  <= {malu[31:2], 2'b00};
            dbus.dbus_wdata <= mb;
            cnt             <= '0;
            fault_q         <= 1'b0;
            state           <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // An ack arriving on the timeout cycle still completes the access.
          if (dbus.dbus_ack) begin
            dbus.dbus_req <= 1'b0;
            rdata_q       <= dbus.dbus_rdata;
            fault_q       <= dbus.dbus_err;
            state         <= ST_DONE;
          end else if (timeout) begin
            dbus.dbus_req <= 1'b0;
            fault_q       <= 1'b1;
            state         <= ST_DONE;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // MEM/WB register; held while stalled. mem_fault is registered so it lines up with the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrn       <= '0;
      wdata     <= '0;
      wwreg     <= 1'b0;
      mem_fault <= 1'b0;
    end else begin
      mem_fault <= 1'b0;
      if (!mem_stall) begin
        wrn <= mrn;
        if (state == ST_DONE) begin
          wdata     <= is_load ? rdata_q : malu;
          wwreg     <= mwreg & ~fault_q & ~mwmem;
          mem_fault <= fault_q;
        end else begin
          // Unstalled outside DONE: either a plain op or a misaligned access.
          wdata     <= malu;
          wwreg     <= mwreg & ~access;
          mem_fault <= access;
        end
      end
    end
  end

endmodule
